lc3b_mem_responder: RTL and testbench



---
 rtl/lc3b_types.sv | 6 +
 rtl/lc3b_mem_array.sv | 39 +++
 rtl/lc3b_mem_responder.sv | 122 ++++++++++++
 tb/tb_lc3b_mem_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-port types and the responder FSM state encoding.
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} lc3b_memresp_state;
endpackage

// File: rtl/lc3b_mem_array.sv
// Word array with one registered read port and one byte-lane-masked write port.
module lc3b_mem_array #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_idx,
  output logic [15:0]          rd_data,
  input  logic                 wr_en,
  input  logic [1:0]           wr_be,
  input  logic [ADDR_BITS-1:0] wr_idx,
  input  logic [15:0]          wr_data
);
  import lc3b_types::*;

  lc3b_word mem_q [2**ADDR_BITS];
  lc3b_word rd_data_q, rd_data_d;

  // Read register keeps its value until the next enabled read.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= 16'h0000;
    else     rd_data_q <= rd_data_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_be[0]) mem_q[wr_idx][7:0]  <= wr_data[7:0];
      if (wr_be[1]) mem_q[wr_idx][15:8] <= wr_data[15:8];
    end
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/lc3b_mem_responder.sv
// Memory-side responder for the LC-3b memory port: fixed-latency service from
// an internal array, one-cycle mem_resp, sticky initiator protocol-error flag.
module lc3b_mem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic        mem_resp,
  output logic [15:0] mem_rdata,
  output logic        protocol_err
);
  import lc3b_types::*;

  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  lc3b_memresp_state state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [14:0]       addr_q, addr_d;
  lc3b_word          wdata_q, wdata_d;
  lc3b_mem_wmask     be_q, be_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;

  logic                 accept;
  logic                 mismatch;
  logic                 enter_resp;
  logic                 reading;
  logic                 arr_rd_en;
  logic [ADDR_BITS-1:0] arr_rd_idx;
  logic                 arr_wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
    rd_q    <= rd_d;
    wr_q    <= wr_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_read || mem_write) state_d = (LATENCY > 1) ? WAIT : RESP;
      WAIT:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, latency countdown and violation tracking.
  always_comb begin
    accept  = (state_q == IDLE) && (mem_read || mem_write);
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (accept) begin
      cnt_d   = CNT_INIT;
      addr_d  = mem_address[15:1];
      wdata_d = mem_wdata;
      be_d    = mem_byte_enable;
      rd_d    = mem_read;
      wr_d    = mem_write;
    end else if (state_q == WAIT && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end

    mismatch = (addr_q != mem_address[15:1]) || (rd_q != mem_read) ||
               (wr_q != mem_write) ||
               (wr_q && ((wdata_q != mem_wdata) || (be_q != mem_byte_enable)));
    err_d = err_q || (accept && mem_read && mem_write) ||
            (((state_q == WAIT) || (state_q == RESP)) && mismatch);
  end

  // On the LATENCY=1 path RESP is entered straight from IDLE, so the read
  // index must come from the live request rather than the latch.
  always_comb begin
    enter_resp = (state_d == RESP) && (state_q != RESP);
    reading    = (state_q == IDLE) ? (mem_read && !mem_write) : (rd_q && !wr_q);
    arr_rd_en  = enter_resp && reading;
    arr_rd_idx = (state_q == IDLE) ? mem_address[ADDR_BITS:1] : addr_q[ADDR_BITS-1:0];
    arr_wr_en  = (state_q == RESP) && wr_q && !rst;
  end

  always_comb begin
    mem_resp     = (state_q == RESP);
    protocol_err = err_q;
  end

  lc3b_mem_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (arr_rd_en),
    .rd_idx  (arr_rd_idx),
    .rd_data (mem_rdata),
    .wr_en   (arr_wr_en),
    .wr_be   (be_q),
    .wr_idx  (addr_q[ADDR_BITS-1:0]),
    .wr_data (wdata_q)
  );
endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Randomized self-checking bench for lc3b_mem_responder against a word-array model.
module tb_lc3b_mem_responder;
  localparam int ADDR_BITS = 8;
  localparam int LATENCY   = 3;
  localparam int DEPTH     = 2**ADDR_BITS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [1:0]  mem_byte_enable = 2'b00;
  logic [15:0] mem_address = 16'h0000, mem_wdata = 16'h0000;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        protocol_err;

  logic        r1_read = 1'b0, r1_write = 1'b0;
  logic [1:0]  r1_be = 2'b00;
  logic [15:0] r1_address = 16'h0000, r1_wdata = 16'h0000;
  logic        r1_resp;
  logic [15:0] r1_rdata;
  logic        r1_err;

  logic [15:0] ref_mem [DEPTH];
  bit          known [DEPTH];
  logic [15:0] last_rdata = 16'h0000;
  bit          err_exp = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lc3b_mem_responder #(.ADDR_BITS(ADDR_BITS), .LATENCY(LATENCY)) u_dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .protocol_err(protocol_err)
  );

  lc3b_mem_responder #(.ADDR_BITS(ADDR_BITS), .LATENCY(1)) u_dut_lat1 (
    .clk(clk), .rst(rst), .mem_read(r1_read), .mem_write(r1_write),
    .mem_byte_enable(r1_be), .mem_address(r1_address),
    .mem_wdata(r1_wdata), .mem_resp(r1_resp), .mem_rdata(r1_rdata),
    .protocol_err(r1_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Counts cycles from request visibility to mem_resp; optionally misbehaves in cycle 1.
  task automatic wait_resp(input int mode, output int got, output logic [15:0] rd);
    got = -1;
    rd  = 16'h0000;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_resp) begin
        got = c;
        rd  = mem_rdata;
        break;
      end
      @(posedge clk); #1;
      if (c == 0) begin
        case (mode)
          1: mem_address = mem_address ^ 16'h0040;
          2: begin mem_read = 1'b0; mem_write = 1'b0; end
          3: mem_wdata = ~mem_wdata;
          default: ;
        endcase
      end
    end
  endtask

  task automatic run_txn(input bit rd, input bit wr, input logic [15:0] addr,
                         input logic [15:0] wd, input logic [1:0] be, input int mode);
    int got;
    int idx;
    logic [15:0] rdv;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; mem_address = addr;
    mem_wdata = wd; mem_byte_enable = be;
    wait_resp(mode, got, rdv);
    check("latency", got, LATENCY);
    idx = (int'(addr) / 2) % DEPTH;
    if (wr) begin
      if (be[0]) ref_mem[idx][7:0]  = wd[7:0];
      if (be[1]) ref_mem[idx][15:8] = wd[15:8];
      if (be == 2'b11) known[idx] = 1'b1;
    end else if (rd) begin
      check("rdata", rdv, ref_mem[idx]);
      last_rdata = ref_mem[idx];
    end
    if ((rd && wr) || mode != 0) err_exp = 1'b1;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    check("resp_idle", mem_resp, 1'b0);
    check("rdata_hold", mem_rdata, last_rdata);
    check("perr", protocol_err, err_exp);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; r1_read = 1'b0; r1_write = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    err_exp = 1'b0;
    last_rdata = 16'h0000;
    @(negedge clk);
    check("rst_resp", mem_resp, 1'b0);
    check("rst_rdata", mem_rdata, 16'h0000);
    check("rst_perr", protocol_err, 1'b0);
  endtask

  initial begin
    int pool [8] = '{8, 9, 16, 17, 40, 100, 200, 255};
    int got, pulses, idx;
    logic [15:0] rdv, addr;

    do_reset();

    run_txn(0, 1, 16'h0010, 16'hBEEF, 2'b11, 0);
    run_txn(1, 0, 16'h0010, 16'h0000, 2'b00, 0);
    check("beef", last_rdata, 16'hBEEF);
    run_txn(0, 1, 16'h0010, 16'h1234, 2'b01, 0);
    run_txn(1, 0, 16'h0010, 16'h0000, 2'b00, 0);
    check("be01", last_rdata, 16'hBE34);
    run_txn(0, 1, 16'h0010, 16'hFFFF, 2'b00, 0);
    run_txn(1, 0, 16'h0011, 16'h0000, 2'b00, 0);
    check("be00", last_rdata, 16'hBE34);
    run_txn(0, 1, 16'h0203, 16'hA5A5, 2'b11, 0);
    run_txn(1, 0, 16'h0002, 16'h0000, 2'b00, 0);
    check("alias", last_rdata, 16'hA5A5);

    for (int i = 0; i < 8; i++)
      run_txn(0, 1, 16'(pool[i] * 2), 16'($urandom), 2'b11, 0);
    for (int i = 0; i < 40; i++) begin
      idx  = pool[$urandom_range(0, 7)];
      addr = 16'(($urandom_range(0, 127) << 9) | (idx << 1) | $urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) run_txn(0, 1, addr, 16'($urandom), 2'($urandom), 0);
      else                           run_txn(1, 0, addr, 16'h0000, 2'b00, 0);
    end

    do_reset();
    run_txn(1, 1, 16'h0030, 16'h7777, 2'b11, 0);
    run_txn(1, 0, 16'h0030, 16'h0000, 2'b00, 0);
    do_reset();
    run_txn(0, 1, 16'h0032, 16'h1357, 2'b11, 1);
    run_txn(1, 0, 16'h0032, 16'h0000, 2'b00, 0);
    do_reset();
    run_txn(1, 0, 16'h0030, 16'h0000, 2'b00, 2);
    do_reset();
    run_txn(0, 1, 16'h0034, 16'h2468, 2'b11, 3);
    run_txn(1, 0, 16'h0034, 16'h0000, 2'b00, 0);

    do_reset();
    run_txn(0, 1, 16'h0020, 16'h1111, 2'b11, 0);
    @(posedge clk); #1;
    mem_write = 1'b1; mem_address = 16'h0020; mem_wdata = 16'h2222; mem_byte_enable = 2'b11;
    @(posedge clk); #1;
    rst = 1'b1; mem_write = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    err_exp = 1'b0;
    last_rdata = 16'h0000;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_resp) pulses++;
    end
    check("rst_abandon", pulses, 0);
    check("rst_abandon_perr", protocol_err, 1'b0);
    run_txn(1, 0, 16'h0020, 16'h0000, 2'b00, 0);
    check("rst_unchanged", last_rdata, 16'h1111);

    @(posedge clk); #1;
    rst = 1'b1; mem_read = 1'b1; mem_address = 16'h0020;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_resp(0, got, rdv);
    check("rst_held_lat", got, LATENCY);
    check("rst_held_rdata", rdv, 16'h1111);
    @(posedge clk); #1;
    mem_read = 1'b0;

    @(posedge clk); #1;
    r1_write = 1'b1; r1_address = 16'h0004; r1_wdata = 16'h5A5A; r1_be = 2'b11;
    @(negedge clk);
    check("l1_w_c0", r1_resp, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("l1_w_c1", r1_resp, 1'b1);
    @(posedge clk); #1;
    r1_write = 1'b0;
    @(posedge clk); #1;
    r1_read = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("l1_pattern", r1_resp, (c % 2 == 1));
      if (r1_resp) begin
        pulses++;
        check("l1_rdata", r1_rdata, 16'h5A5A);
      end
      @(posedge clk); #1;
    end
    r1_read = 1'b0;
    check("l1_pulses", pulses, 3);
    @(negedge clk);
    check("l1_perr", r1_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
